// File: rtl/red_pitaya_bus_pkg.sv
// red_pitaya_bus_pkg: shared types and widths for the DSP bus master
package red_pitaya_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
    localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/red_pitaya_cmd_fifo.sv
// red_pitaya_cmd_fifo: synchronous FIFO with registered read data
module red_pitaya_cmd_fifo #(
    parameter int W = 69,
    parameter int D = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(D);
    localparam logic [AW:0] DCNT = D[AW:0];
    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign full    = cnt == DCNT;
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // storage array, written on an accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wp] <= din;
    end
    // pointers, occupancy and output register; a pop loads the head entry into dout
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_pop) dout <= mem[rp];
        end
    end
endmodule

// File: rtl/red_pitaya_bus_master.sv
// red_pitaya_bus_master: FIFO-buffered command replay onto the DSP system bus with ack timeout
module red_pitaya_bus_master
    import red_pitaya_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sys_addr_o,
    output logic [DATA_W-1:0] sys_wdata_o,
    output logic [SEL_W-1:0]  sys_sel_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [DATA_W-1:0] sys_rdata_i,
    input  logic              sys_err_i,
    input  logic              sys_ack_i
);
    state_t      state, nxt;
    cmd_t        cmd_in, req;
    logic        pop, empty, full, expired;
    logic [15:0] timer, tmr_inc;
    assign cmd_in = {cmd_we_i, cmd_sel_i, cmd_addr_i, cmd_wdata_i};
    // the FIFO output register doubles as the request register: it only changes on a pop in IDLE
    red_pitaya_cmd_fifo #(.W(CMD_W), .D(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (cmd_valid_i),
        .pop    (pop),
        .din    (cmd_in),
        .dout   (req),
        .full   (full),
        .empty  (empty)
    );
    assign cmd_ready_o = !full;
    assign tmr_inc     = timer + 16'(timer != 16'hFFFF);
    assign expired     = tmr_inc >= 16'(TIMEOUT);
    assign sys_addr_o  = req.addr;
    assign sys_wdata_o = req.wdata;
    assign sys_sel_o   = req.sel;
    assign sys_wen_o   = state == ISSUE && req.we;
    assign sys_ren_o   = state == ISSUE && !req.we;
    assign rsp_valid_o = state == RESP;
    assign busy_o      = state != IDLE || !empty;
    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= nxt;
    end
    // next state and FIFO pop
    always_comb begin
        nxt = state;
        pop = 1'b0;
        case (state)
            IDLE:    if (!empty) begin pop = 1'b1; nxt = ISSUE; end
            ISSUE:   nxt = WAIT;
            WAIT:    if (sys_ack_i || expired) nxt = RESP;
            RESP:    if (rsp_ready_i) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // saturating wait timer, cleared on the strobe cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)              timer <= '0;
        else if (state == ISSUE)  timer <= '0;
        else if (state == WAIT)   timer <= tmr_inc;
    end
    // response capture on leaving WAIT; an ack takes priority over expiry
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else if (state == WAIT && sys_ack_i) begin
            rsp_rdata_o   <= req.we ? '0 : sys_rdata_i;
            rsp_err_o     <= sys_err_i;
            rsp_timeout_o <= 1'b0;
        end else if (state == WAIT && expired) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_red_pitaya_bus_master.sv
// tb_red_pitaya_bus_master: directed scenario checks for the bus master
module tb_red_pitaya_bus_master;
    logic        clk = 0, rstn = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic [3:0]  cmd_sel = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_err, rsp_to, busy;
    logic [31:0] rsp_rdata, sys_addr, sys_wdata, sys_rdata = 0;
    logic [3:0]  sys_sel;
    logic        wen, ren, sys_err = 0, ack = 0;
    int          checks = 0, errors = 0;

    red_pitaya_bus_master #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to), .busy_o(busy),
        .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel),
        .sys_wen_o(wen), .sys_ren_o(ren),
        .sys_rdata_i(sys_rdata), .sys_err_i(sys_err), .sys_ack_i(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_sel = s;
        step();
        cmd_valid = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to, busy, sys_addr, sys_wdata, sys_sel, wen, ren} !== 106'd0) begin errors++; $display("FAIL reset_outputs got nonzero busy=%b valid=%b", busy, rsp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        step(); step();
        rstn = 1;
        step();
    endtask

    task automatic test_single_write();
        push_cmd(1, 32'h40300004, 32'h2, 4'hF);
        checks++; if (wen !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_t1 wen=%b busy=%b exp 0/1", wen, busy); end
        step();
        checks++; if ({wen, ren} !== 2'b10) begin errors++; $display("FAIL wr_strobe got %b exp 10", {wen, ren}); end
        checks++; if ({sys_addr, sys_wdata, sys_sel} !== {32'h40300004, 32'h2, 4'hF}) begin errors++; $display("FAIL wr_fields got %h %h %h", sys_addr, sys_wdata, sys_sel); end
        step();
        checks++; if (wen !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_t3 wen=%b valid=%b exp 0/0", wen, rsp_valid); end
        ack = 1; sys_rdata = 32'h12345678;
        step();
        ack = 0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL wr_rsp got v=%b d=%h e=%b t=%b exp 1 0 0 0", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop got %b exp 0", rsp_valid); end
    endtask

    task automatic test_read_slow();
        push_cmd(0, 32'h40300008, 32'h0, 4'hF);
        step();
        checks++; if ({wen, ren} !== 2'b01) begin errors++; $display("FAIL rd_strobe got %b exp 01", {wen, ren}); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (sys_addr !== 32'h40300008 || rsp_valid !== 1'b0 || ren !== 1'b0) begin errors++; $display("FAIL rd_wait%0d addr=%h valid=%b ren=%b", i, sys_addr, rsp_valid, ren); end
            if (i == 3) begin ack = 1; sys_rdata = 32'h3; end
        end
        step();
        ack = 0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'h3, 2'b00}) begin errors++; $display("FAIL rd_rsp got v=%b d=%h e=%b t=%b exp 1 3 0 0", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        push_cmd(0, 32'h40300010, 32'h0, 4'h3);
        step();
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL to_strobe got %b exp 1", ren); end
        sys_rdata = 32'hFFFFFFFF;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (rsp_valid !== 1'b0 || sys_addr !== 32'h40300010) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", bad); end
        step();
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'h0, 2'b11}) begin errors++; $display("FAIL to_rsp got v=%b d=%h e=%b t=%b exp 1 0 1 1", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step(); step(); step();
        push_cmd(1, 32'h40300014, 32'h7, 4'hF);
        step();
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL late_strobe got %b exp 1", wen); end
        ack = 1; sys_err = 1; sys_rdata = 32'hBAD;
        step();
        ack = 0; sys_err = 0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL late_ack_taken got valid %b exp 0", rsp_valid); end
        step();
        ack = 1;
        step();
        ack = 0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL late_rsp got v=%b d=%h e=%b t=%b exp 1 0 0 0", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step();
    endtask

    task automatic test_error_ack();
        push_cmd(0, 32'h40300020, 32'h0, 4'hF);
        step();
        step();
        ack = 1; sys_err = 1; sys_rdata = 32'hDEADBEEF;
        step();
        ack = 0; sys_err = 0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'hDEADBEEF, 2'b10}) begin errors++; $display("FAIL err_rsp got v=%b d=%h e=%b t=%b exp 1 deadbeef 1 0", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bp_addr [6];
        logic        bp_we [6];
        int pushed = 0, issued = 0, last = -100;
        logic sp = 0;
        for (int i = 0; i < 6; i++) begin bp_addr[i] = 32'h40300100 + 32'(i * 4); bp_we[i] = i[0]; end
        sys_rdata = 0;
        for (int c = 0; c < 60 && issued < 6; c++) begin
            rsp_ready = c >= 6;
            ack = sp;
            cmd_valid = pushed < 6;
            if (pushed < 6) begin cmd_addr = bp_addr[pushed]; cmd_we = bp_we[pushed]; cmd_wdata = 32'(pushed); cmd_sel = 4'hF; end
            if (c == 4) begin checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready4 got %b exp 1", cmd_ready); end end
            if (c == 5) begin checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_full ready=%b valid=%b exp 0/1", cmd_ready, rsp_valid); end end
            sp = wen | ren;
            if (sp) begin
                checks++; if (sys_addr !== bp_addr[issued] || wen !== bp_we[issued]) begin errors++; $display("FAIL bp_order%0d addr=%h wen=%b exp %h %b", issued, sys_addr, wen, bp_addr[issued], bp_we[issued]); end
                if (issued > 0) begin checks++; if (c - last < 4) begin errors++; $display("FAIL bp_gap%0d got %0d exp >=4", issued, c - last); end end
                last = c;
                issued++;
            end
            if (cmd_valid && cmd_ready) pushed++;
            step();
        end
        cmd_valid = 0;
        checks++; if (issued !== 6) begin errors++; $display("FAIL bp_issued got %0d exp 6", issued); end
        ack = 1;
        step();
        ack = 0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_last_rsp got %b exp 1", rsp_valid); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        push_cmd(0, 32'h40300030, 32'h0, 4'hF);
        step();
        step();
        checks++; if (busy !== 1'b1 || sys_addr !== 32'h40300030) begin errors++; $display("FAIL rw_pre busy=%b addr=%h", busy, sys_addr); end
        #2 rstn = 0;
        #1;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to, busy, sys_addr, sys_wdata, sys_sel, wen, ren} !== 106'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rw_async busy=%b addr=%h ready=%b exp 0 0 1", busy, sys_addr, cmd_ready); end
        step(); step();
        rstn = 1;
        step();
        ack = 1; sys_rdata = 32'h55;
        step();
        ack = 0;
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ren !== 1'b0) begin errors++; $display("FAIL rw_ghost valid=%b busy=%b ren=%b exp 0", rsp_valid, busy, ren); end
        push_cmd(1, 32'h40300040, 32'hA5, 4'h1);
        step();
        checks++; if ({wen, sys_addr, sys_wdata, sys_sel} !== {1'b1, 32'h40300040, 32'hA5, 4'h1}) begin errors++; $display("FAIL rw_new_strobe wen=%b addr=%h", wen, sys_addr); end
        step();
        ack = 1;
        step();
        ack = 0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_to} !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL rw_new_rsp got v=%b d=%h e=%b t=%b exp 1 0 0 0", rsp_valid, rsp_rdata, rsp_err, rsp_to); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_slow();
        test_timeout();
        test_error_ack();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
